// File: rtl/seg7_pkg.sv
// Shared definitions for seven-segment display blocks: segment table,
// active-low segment builder, digit count and the per-slot state type.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } slot_state_e;

  // Active-high segments, bit order g,f,e,d,c,b,a, indexed by hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_seg_n(input logic [3:0] nibble);
    return ~SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-low segment decoder built on the shared
// package table so other display blocks can reuse it unchanged.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = hex_seg_n(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode multiplexed hex display driver with per-frame input
// snapshot, inter-digit blanking and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int LZ_BLANK  = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DP_IN,
  output logic [6:0]  SEG_N,
  output logic        DP_N,
  output logic [3:0]  AN_N,
  output logic        FRAME
);

  localparam int PH_W = $clog2(SCAN_DIV);
  localparam int DG_W = $clog2(NUM_DIGITS);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(SCAN_DIV - 1);
  localparam logic [PH_W-1:0] BLANK_LAST = PH_W'(BLANK_CYC - 1);

  logic [PH_W-1:0] phase;
  logic [DG_W-1:0] digit;
  slot_state_e     state;
  logic [15:0]     shadow_data;
  logic [3:0]      shadow_dp;
  logic            snap;
  logic [3:0]      nibble;
  logic [6:0]      seg_dec;
  logic [3:0]      nib_zero;
  logic [3:0]      lz_mask;
  logic            digit_blank;

  assign snap   = (digit == '0) && (phase == '0);
  assign nibble = shadow_data[{digit, 2'b00} +: 4];

  // A digit is suppressed only when it and every digit to its left are zero;
  // the rightmost digit always shows.
  assign nib_zero[0] = (shadow_data[3:0]   == 4'h0);
  assign nib_zero[1] = (shadow_data[7:4]   == 4'h0);
  assign nib_zero[2] = (shadow_data[11:8]  == 4'h0);
  assign nib_zero[3] = (shadow_data[15:12] == 4'h0);
  assign lz_mask = (LZ_BLANK != 0) ?
                   {nib_zero[3],
                    nib_zero[3] & nib_zero[2],
                    nib_zero[3] & nib_zero[2] & nib_zero[1],
                    1'b0} : 4'b0000;
  assign digit_blank = lz_mask[digit];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg_n  (seg_dec)
  );

  // Counters, slot state and frame snapshot
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase       <= '0;
      digit       <= '0;
      state       <= BLANK;
      shadow_data <= '0;
      shadow_dp   <= '0;
      FRAME       <= 1'b0;
    end else begin
      if (phase == PH_LAST) begin
        phase <= '0;
        digit <= digit + 1'b1;
        state <= BLANK;
      end else begin
        phase <= phase + 1'b1;
        if (phase == BLANK_LAST) state <= SHOW;
      end
      if (snap) begin
        shadow_data <= DATA_IN;
        shadow_dp   <= DP_IN;
      end
      FRAME <= snap;
    end
  end

  // Registered display drive, one clock behind the counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      AN_N  <= 4'hF;
      SEG_N <= 7'h7F;
      DP_N  <= 1'b1;
    end else if (state == BLANK) begin
      AN_N  <= 4'hF;
      SEG_N <= 7'h7F;
      DP_N  <= 1'b1;
    end else begin
      AN_N  <= ~(4'b0001 << digit);
      SEG_N <= digit_blank ? 7'h7F : seg_dec;
      DP_N  <= ~shadow_dp[digit];
    end
  end

endmodule
